// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch stage between the PC and decode.
// Issues at most one read per cycle to a synchronous instruction ROM at the
// current PC, captures each returned word with its fetch address in a small
// show-ahead FIFO, and hands the head to decode over a valid/ready handshake.
// A flush drops all queued entries and any read still in flight.
//
// Ports:
//   clk        system clock, rising-edge
//   rst        synchronous active-low reset
//   pc_addr    current PC value
//   pc_inc     fetch issued this cycle; PC advances at next edge (comb)
//   mem_addr   ROM read address, equals pc_addr (comb)
//   mem_rd     ROM read strobe, equals pc_inc (comb)
//   mem_rdata  ROM data, valid one cycle after mem_rd
//   flush      discard queued and in-flight fetches
//   inst_valid FIFO head valid
//   inst_ready decode accepts head
//   inst_data  instruction at FIFO head
//   inst_pc    fetch address of inst_data
module inst_fetch_queue #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_addr,
    output logic          pc_inc,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_rdata,
    input  logic          flush,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [DW-1:0] inst_data,
    output logic [AW-1:0] inst_pc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = CW + 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_inflight;
    logic [AW-1:0] r_inflight_pc;
    logic [DW-1:0] r_data_mem [DEPTH];
    logic [AW-1:0] r_pc_mem   [DEPTH];
    logic [DW-1:0] r_last_data;
    logic [AW-1:0] r_last_pc;

    logic [OW-1:0] w_occupancy;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;

    // Occupancy counts the in-flight read so a return always has a free slot.
    assign w_occupancy = OW'(r_count) + OW'(r_inflight);
    assign w_issue     = rst & ~flush & (w_occupancy < OW'(DEPTH));
    assign w_push      = r_inflight & ~flush;
    assign w_pop       = inst_valid & inst_ready & ~flush;

    assign pc_inc   = w_issue;
    assign mem_rd   = w_issue;
    assign mem_addr = pc_addr;

    // Head is shown directly; when empty the last presented value is held.
    assign inst_valid = (r_count != '0);
    assign inst_data  = inst_valid ? r_data_mem[r_rd_ptr] : r_last_data;
    assign inst_pc    = inst_valid ? r_pc_mem[r_rd_ptr]   : r_last_pc;

    // Issue tracking: remembers the address of the read whose data lands next cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= pc_addr;
            end
        end
    end

    // FIFO pointers and occupancy; flush drops the contents by aligning rd to wr.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are meaningful only between rd and wr pointers.
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_data_mem[r_wr_ptr] <= mem_rdata;
            r_pc_mem[r_wr_ptr]   <= r_inflight_pc;
        end
    end

    // Holding copy of the presented head for cycles where the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_data <= '0;
            r_last_pc   <= '0;
        end else begin
            r_last_data <= inst_data;
            r_last_pc   <= inst_pc;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: PC model, ROM model (word = addr ^ A5A5_0000),
// directed phases, and a scoreboard monitor checking every accepted head.
module tb_inst_fetch_queue;

    localparam logic [31:0] XORV  = 32'hA5A5_0000;
    localparam logic [31:0] REDIR = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_q;
    logic [31:0] pc_addr;
    logic        pc_inc;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        flush;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    int n_tests   = 0;
    int n_fail    = 0;
    int mon_tests = 0;
    int mon_fail  = 0;
    int n_pop     = 0;

    logic [31:0] sb[$];

    inst_fetch_queue #(.AW(32), .DW(32), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_addr    (pc_addr),
        .pc_inc     (pc_inc),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .flush      (flush),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_data  (inst_data),
        .inst_pc    (inst_pc)
    );

    initial forever #5 clk = ~clk;

    assign pc_addr = pc_q;

    always @(posedge clk) begin
        if (!rst)        pc_q <= 32'h0;
        else if (flush)  pc_q <= REDIR;
        else if (pc_inc) pc_q <= pc_q + 32'd4;
    end

    always @(posedge clk) begin
        mem_rdata <= mem_rd ? (mem_addr ^ XORV) : 32'hDEAD_BEEF;
    end

    logic rst_q   = 1'b0;
    logic flush_q = 1'b0;
    always @(posedge clk) begin
        rst_q   <= rst;
        flush_q <= flush;
    end

    // Monitor: pops the scoreboard on every accepted head and checks hold stability.
    task automatic mchk(input string name, input logic [31:0] act, input logic [31:0] exp);
        mon_tests++;
        if (act !== exp) begin
            mon_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic        hold_prev = 1'b0;
    logic [31:0] prev_pc   = 32'h0;
    logic [31:0] prev_data = 32'h0;

    always @(negedge clk) begin
        logic [31:0] e;
        if (hold_prev && rst_q && !flush_q) begin
            mchk("hold_valid", 32'(inst_valid), 32'd1);
            mchk("hold_pc",    inst_pc,   prev_pc);
            mchk("hold_data",  inst_data, prev_data);
        end
        if (rst && !flush && inst_valid && inst_ready) begin
            if (sb.size() == 0) begin
                mchk("sb_unexpected_pop", inst_pc, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                mchk("sb_pc",   inst_pc,   e);
                mchk("sb_data", inst_data, e ^ XORV);
                n_pop++;
            end
        end
        hold_prev = rst && !flush && inst_valid && !inst_ready;
        prev_pc   = inst_pc;
        prev_data = inst_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) sb.push_back(base + 32'(4 * k));
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        flush      = 1'b0;
        inst_ready = 1'b0;
        sb.delete();
        @(negedge clk);
        step();
        rst = 1'b1;
    endtask

    initial begin
        int base;
        int n_inc;
        rst        = 1'b0;
        flush      = 1'b0;
        inst_ready = 1'b1;
        #1;

        // Reset/idle: three reset cycles with ready high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_valid",  32'(inst_valid), 32'd0);
            chk("rst_data",   inst_data,       32'h0);
            chk("rst_pc",     inst_pc,         32'h0);
            chk("rst_pc_inc", 32'(pc_inc),     32'd0);
            step();
        end

        // Streaming: one fetch per cycle, first head two cycles after first issue
        rst = 1'b1;
        sb.delete();
        push_seq(32'h0, 24);
        base = n_pop;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk("stream_pc_inc",   32'(pc_inc), 32'd1);
            chk("stream_mem_addr", mem_addr,    32'(4 * c));
            if (c < 2) chk("stream_lat_valid", 32'(inst_valid), 32'd0);
            if (c == 2) begin
                chk("stream_first_valid", 32'(inst_valid), 32'd1);
                chk("stream_first_pc",    inst_pc,         32'h0);
                chk("stream_first_data",  inst_data,       32'hA5A5_0000);
            end
            step();
        end
        chk("stream_pops", 32'(n_pop - base), 32'd14);

        // Backpressure: exactly four issues, then one more after a single pop
        do_reset();
        push_seq(32'h0, 24);
        n_inc = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_inc += int'(pc_inc);
            step();
        end
        chk("bp_issue_count", 32'(n_inc), 32'd4);
        @(negedge clk);
        chk("bp_full_pc_inc", 32'(pc_inc),     32'd0);
        chk("bp_full_valid",  32'(inst_valid), 32'd1);
        chk("bp_full_head",   inst_pc,         32'h0);
        step();
        inst_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop_no_credit", 32'(pc_inc), 32'd0);
        step();
        inst_ready = 1'b0;
        n_inc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("bp_new_head",  inst_pc,  32'h4);
                chk("bp_resume_ad", mem_addr, 32'h10);
            end
            n_inc += int'(pc_inc);
            step();
        end
        chk("bp_resume_count", 32'(n_inc), 32'd1);
        inst_ready = 1'b1;
        for (int c = 0; c < 8; c++) step();

        // Flush with a read in flight and redirect to 0x100
        do_reset();
        push_seq(32'h0, 3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("fl_pre_addr", mem_addr, 32'(4 * c));
            step();
        end
        flush = 1'b1;
        @(negedge clk);
        chk("fl_no_issue",  32'(pc_inc),     32'd0);
        chk("fl_pre_valid", 32'(inst_valid), 32'd1);
        sb.delete();
        push_seq(REDIR, 24);
        step();
        flush      = 1'b0;
        inst_ready = 1'b1;
        base = n_pop;
        for (int c = 4; c < 14; c++) begin
            @(negedge clk);
            if (c == 4) begin
                chk("fl_valid_drop", 32'(inst_valid), 32'd0);
                chk("fl_resume",     32'(pc_inc),     32'd1);
                chk("fl_redir_addr", mem_addr,        REDIR);
            end
            if (c == 6) chk("fl_first_pc", inst_pc, REDIR);
            step();
        end
        chk("fl_pops", 32'(n_pop - base), 32'd8);

        // Simultaneous push and pop at two entries: steady flow, order kept
        do_reset();
        push_seq(32'h0, 24);
        for (int c = 0; c < 3; c++) step();
        inst_ready = 1'b1;
        base = n_pop;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("pp_pc_inc", 32'(pc_inc),     32'd1);
            chk("pp_valid",  32'(inst_valid), 32'd1);
            step();
        end
        chk("pp_pops", 32'(n_pop - base), 32'd10);

        // Reset with three queued entries and one read in flight
        do_reset();
        for (int c = 0; c < 4; c++) step();
        @(negedge clk);
        chk("mr_full_pc_inc", 32'(pc_inc),     32'd0);
        chk("mr_full_valid",  32'(inst_valid), 32'd1);
        chk("mr_full_head",   inst_pc,         32'h0);
        rst = 1'b0;
        sb.delete();
        push_seq(32'h0, 24);
        step();
        rst        = 1'b1;
        inst_ready = 1'b1;
        base = n_pop;
        for (int c = 5; c < 11; c++) begin
            @(negedge clk);
            if (c == 5) begin
                chk("mr_valid",   32'(inst_valid), 32'd0);
                chk("mr_data",    inst_data,       32'h0);
                chk("mr_pc",      inst_pc,         32'h0);
                chk("mr_restart", 32'(pc_inc),     32'd1);
                chk("mr_addr",    mem_addr,        32'h0);
            end
            step();
        end
        chk("mr_pops", 32'(n_pop - base), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests + mon_tests, n_fail + mon_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Fetch stage directly downstream of the program counter (`pc`).
- Each cycle it may issue one read at the current PC to an external synchronous instruction ROM and pulse `pc_inc` so the PC advances.
- Returned words are buffered, each with its fetch address, in a small FIFO presented to decode over a valid/ready handshake.
- A `flush` input discards buffered and in-flight fetches on redirect.

Parameters:
- AW, 32, width of PC / instruction address.
- DW, 32, instruction word width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- pc_addr  input  AW  current PC value from the pc block.
- pc_inc  output  1  combinational; 1 = fetch issued this cycle, pc advances at next edge.
- mem_addr  output  AW  combinational; ROM read address, equals pc_addr.
- mem_rd  output  1  combinational; ROM read strobe, equals pc_inc.
- mem_rdata  input  DW  ROM data, valid exactly 1 cycle after mem_rd.
- flush  input  1  discard all queued and in-flight fetches.
- inst_valid  output  1  FIFO head holds a valid instruction.
- inst_ready  input  1  decode accepts head this cycle.
- inst_data  output  DW  instruction at FIFO head (show-ahead).
- inst_pc  output  AW  fetch address of inst_data.

Behaviour:
- Reset (rst=0 at a rising edge): count=0, inflight=0, wr/rd pointers=0, inflight_pc=0.
  - Resulting outputs: inst_valid=0, inst_data=0, inst_pc=0, pc_inc=0, mem_rd=0.
  - Reset overrides flush and all other inputs.
  - Reset mid-fetch drops the pending ROM return.
- State:
  - count (0..DEPTH) = entries in FIFO.
  - inflight (1 bit) = a read issued last cycle whose data arrives this cycle.
  - inflight_pc = address of that read.
- Issue condition:
  - pc_inc = mem_rd = rst & ~flush & (count + inflight < DEPTH).
  - A same-cycle pop is not credited; sizing is conservative, so overflow is never possible.
- Issue edge: inflight<=pc_inc; inflight_pc<=pc_addr when pc_inc.
- Return:
  - When inflight=1 and flush=0, push {inflight_pc, mem_rdata} at wr_ptr.
  - Latency pc_inc→inst_valid is 2 cycles for an empty FIFO: issue in cycle N, capture at edge N+1→N+2, visible in N+2.
- Pop: inst_valid & inst_ready advances rd_ptr.
  - Simultaneous push and pop leaves count unchanged.
  - Push into an empty FIFO plus pop is impossible: head is not valid yet.
- Outputs:
  - inst_valid = (count != 0).
  - inst_data/inst_pc read from rd_ptr entry.
  - When count=0, inst_data/inst_pc hold their last value; 0 after reset.
- Handshake rules:
  - inst_valid never drops without a pop or flush.
  - inst_data/inst_pc are stable while inst_valid & ~inst_ready.
- Flush (rst=1, flush=1) at the edge:
  - count<=0 and rd_ptr<=wr_ptr.
  - inflight<=0, so the in-flight return is discarded.
  - No issue this cycle.
  - Next cycle: inst_valid=0; issue resumes if flush has dropped. The pc block is redirected externally.
  - Flush with inst_ready=1: the head is considered dropped, not consumed.
- Full (count + inflight = DEPTH): pc_inc=0, PC holds.
  - Issue resumes the cycle after a pop reduces occupancy.
- Pointer wrap: log2(DEPTH)-bit pointers wrap modulo DEPTH.
- Steady-state throughput: with inst_ready=1 continuously, one instruction per cycle.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles with inst_ready=1 → inst_valid=0, inst_data=0, inst_pc=0, pc_inc=0 throughout.
- Streaming: release rst, ROM word = addr^32'hA5A5_0000, PC increments by 4 from 0, inst_ready=1 → pc_inc=1 every cycle.
  - First inst_valid 2 cycles after first pc_inc with inst_pc=0, inst_data=32'hA5A5_0000.
  - Thereafter inst_pc=4, 8, 12, … one per cycle, no gaps.
- Backpressure/full: DEPTH=4, inst_ready=0 → exactly 4 pc_inc pulses (addrs 0, 4, 8, 12), then pc_inc=0.
  - inst_pc holds 0 stably.
  - Raise inst_ready for 1 cycle → pop addr 0; new head addr 4; exactly one further pc_inc (addr 16).
- Flush with data in flight: after issuing 0, 4, 8 with inst_ready=0, assert flush one cycle while pc_addr is redirected to 32'h100.
  - Next cycle inst_valid=0.
  - Return for addr 8 is not enqueued.
  - Subsequent inst_pc sequence is 0x100, 0x104, ….
- Simultaneous push/pop at count=2: inst_ready=1 during a return → count stays 2, order preserved, no duplicate or lost inst_pc.
- Reset mid-operation: FIFO holding 3 entries plus one in flight, pulse rst=0 for 1 cycle → next cycle inst_valid=0, inst_data=0, inst_pc=0.
  - The in-flight word never appears at the output.
